// File: rtl/axis_cp_insert.sv
// rtl/axis_cp_insert.sv - cyclic-prefix inserter: buffers one N-sample OFDM symbol
// and replays it as CP_LEN tail samples followed by the full symbol.
module axis_cp_insert #(
  parameter int N      = 64,
  parameter int CP_LEN = 8,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              done_tick,
  output logic              tlast_err
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_RD   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_WR   = CW'(N + CP_LEN - 1);
  localparam logic [AW-1:0] CP_OFFSET = AW'(N - CP_LEN);

  typedef enum logic [1:0] {S_READ, S_PREP, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tlast_err_q, tlast_err_d;
  logic              mem_we;
  logic [AW-1:0]     k_next;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] mem [N];

  // Output index k maps to symbol address (N - CP_LEN + k) mod N, covering prefix and body alike.
  assign k_next  = (state_q == S_WRITE) ? AW'(wr_cnt_q + 1'b1) : '0;
  assign rd_addr = CP_OFFSET + k_next;
  assign rd_data = mem[rd_addr];

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tlast_err_d = tlast_err_q;
    mem_we      = 1'b0;
    case (state_q)
      S_READ: begin
        if (s_axis_tvalid) begin
          mem_we = 1'b1;
          if (rd_cnt_q == LAST_RD) begin
            rd_cnt_d = '0;
            state_d  = S_PREP;
            if (!s_axis_tlast) tlast_err_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (s_axis_tlast) tlast_err_d = 1'b1;
          end
        end
      end
      S_PREP: begin
        tdata_d  = rd_data;
        wr_cnt_d = '0;
        tlast_d  = 1'b0;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (m_axis_tready) begin
          if (wr_cnt_q == LAST_WR) begin
            tlast_d = 1'b0;
            state_d = S_DONE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            tdata_d  = rd_data;
            tlast_d  = ((wr_cnt_q + 1'b1) == LAST_WR);
          end
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_READ;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tlast_err_q <= tlast_err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[rd_cnt_q[AW-1:0]] <= s_axis_tdata;
  end

  assign s_axis_tready = (state_q == S_READ);
  assign m_axis_tvalid = (state_q == S_WRITE);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign done_tick     = (state_q == S_DONE);
  assign tlast_err     = tlast_err_q;

endmodule

// File: tb/tb_axis_cp_insert.sv
// tb/tb_axis_cp_insert.sv - bench for axis_cp_insert: three parameterisations,
// ramp and random symbols, gaps, back-pressure, tlast errors and mid-frame reset.
`timescale 1ns/1ps
module tb_axis_cp_insert;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_tready;
  logic          s_tvalid [3];
  logic          s_tready [3];
  logic [DW-1:0] m_tdata  [3];
  logic          m_tvalid [3];
  logic          m_tlast  [3];
  logic          done     [3];
  logic          err      [3];

  int sel;
  logic          cur_s_tready, cur_tvalid, cur_tlast, cur_done;
  logic [DW-1:0] cur_tdata;
  always_comb begin
    cur_s_tready = s_tready[sel];
    cur_tvalid   = m_tvalid[sel];
    cur_tlast    = m_tlast[sel];
    cur_done     = done[sel];
    cur_tdata    = m_tdata[sel];
  end

  axis_cp_insert #(.N(64), .CP_LEN(8), .DATA_W(DW)) u_n64 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
    .done_tick(done[0]), .tlast_err(err[0]));
  axis_cp_insert #(.N(16), .CP_LEN(4), .DATA_W(DW)) u_n16_cp4 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
    .done_tick(done[1]), .tlast_err(err[1]));
  axis_cp_insert #(.N(16), .CP_LEN(1), .DATA_W(DW)) u_n16_cp1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tready(s_tready[2]), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid[2]), .s_axis_tlast(s_tlast), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tlast(m_tlast[2]),
    .done_tick(done[2]), .tlast_err(err[2]));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] din  [$];
  logic [DW-1:0] expq [$];
  time last_drive_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ramp(input int n, input int base);
    din = {};
    for (int i = 0; i < n; i++) din.push_back(DW'(base + i));
  endtask

  task automatic rnd(input int n);
    din = {};
    for (int i = 0; i < n; i++) din.push_back($urandom);
  endtask

  task automatic drive(input int n, input bit gap, input int tlast_at);
    int i = 0;
    int cyc = 0;
    while (i < n) begin
      @(negedge aclk);
      cyc++;
      if (gap && (cyc % 3 == 0)) begin
        s_tvalid[sel] = 1'b0;
        s_tlast       = 1'b0;
      end else begin
        chk("s_tready_capture", {31'b0, cur_s_tready}, 32'd1);
        s_tvalid[sel] = 1'b1;
        s_tdata       = din[i];
        s_tlast       = (i == tlast_at);
        last_drive_t  = $time;
        i++;
      end
    end
    @(negedge aclk);
    s_tvalid[sel] = 1'b0;
    s_tlast       = 1'b0;
    chk("s_tready_prep", {31'b0, cur_s_tready}, 32'd0);
  endtask

  // mode 0: tready high, 1: pattern 1,0,0,1, 2: random
  task automatic collect(input int mode, input int abort_at);
    int hs = 0, cyc = 0, last_hs = -10, pat = 0;
    bit first = 1'b1, fin = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    while (!fin && cyc < 3000) begin
      @(negedge aclk);
      cyc++;
      case (mode)
        0:       m_tready = 1'b1;
        1:       begin m_tready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (pv && !pr) begin
        chk("stall_tvalid", {31'b0, cur_tvalid}, 32'd1);
        chk("stall_tdata", cur_tdata, pd);
        chk("stall_tlast", {31'b0, cur_tlast}, {31'b0, pl});
      end
      if (cur_done) begin
        chk("done_tvalid", {31'b0, cur_tvalid}, 32'd0);
        chk("done_after_last", 32'(cyc - last_hs), 32'd1);
        chk("handshake_count", 32'(hs), 32'(expq.size()));
        fin = 1'b1;
      end else if (cur_tvalid) begin
        if (first) begin
          chk("first_valid_latency", 32'(($time - last_drive_t) / 10), 32'd2);
          first = 1'b0;
        end
        chk("s_tready_output", {31'b0, cur_s_tready}, 32'd0);
        if (abort_at >= 0 && hs == abort_at) begin
          #2 aresetn = 1'b0;
          #1;
          chk("abort_tvalid", {31'b0, cur_tvalid}, 32'd0);
          chk("abort_tlast", {31'b0, cur_tlast}, 32'd0);
          chk("abort_done", {31'b0, cur_done}, 32'd0);
          chk("abort_tdata", cur_tdata, 32'd0);
          return;
        end
        if (m_tready) begin
          chk("tdata", cur_tdata, expq[hs]);
          chk("tlast", {31'b0, cur_tlast}, {31'b0, hs == expq.size() - 1});
          hs++;
          last_hs = cyc;
        end
      end
      pv = cur_tvalid; pr = m_tready; pd = cur_tdata; pl = cur_tlast;
    end
    chk("frame_done", {31'b0, fin}, 32'd1);
    @(negedge aclk);
    chk("done_one_cycle", {31'b0, cur_done}, 32'd0);
    chk("idle_tvalid", {31'b0, cur_tvalid}, 32'd0);
  endtask

  // Expected frame: the last cp samples of the symbol, then the whole symbol.
  task automatic run(input int s, input bit gap, input int mode, input int tlast_at, input int abort_at);
    int n  = (s == 0) ? 64 : 16;
    int cp = (s == 0) ? 8 : ((s == 1) ? 4 : 1);
    sel  = s;
    expq = {};
    for (int k = n - cp; k < n; k++) expq.push_back(din[k]);
    for (int k = 0; k < n; k++) expq.push_back(din[k]);
    fork
      drive(n, gap, tlast_at);
      collect(mode, abort_at);
    join
  endtask

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    sel      = 0;
    for (int d = 0; d < 3; d++) s_tvalid[d] = 1'b0;
    repeat (3) @(negedge aclk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_tvalid", {31'b0, m_tvalid[d]}, 32'd0);
      chk("rst_tlast", {31'b0, m_tlast[d]}, 32'd0);
      chk("rst_tdata", m_tdata[d], 32'd0);
      chk("rst_done", {31'b0, done[d]}, 32'd0);
      chk("rst_err", {31'b0, err[d]}, 32'd0);
      chk("rst_s_tready", {31'b0, s_tready[d]}, 32'd1);
    end
    @(negedge aclk);
    aresetn = 1'b1;

    ramp(64, 0);   run(0, 1'b0, 0, 63, -1);
    ramp(64, 0);   run(0, 1'b0, 1, 63, -1);
    ramp(64, 0);   run(0, 1'b1, 0, 63, -1);
    rnd(64);       run(0, 1'b1, 2, 63, -1);
    chk("err_clean", {31'b0, err[0]}, 32'd0);

    ramp(64, 0);   run(0, 1'b0, 0, 40, -1);
    chk("err_set", {31'b0, err[0]}, 32'd1);
    rnd(64);       run(0, 1'b0, 2, 63, -1);
    chk("err_sticky", {31'b0, err[0]}, 32'd1);

    ramp(64, 0);   run(0, 1'b0, 0, 63, 30);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    chk("err_cleared", {31'b0, err[0]}, 32'd0);
    chk("post_abort_s_tready", {31'b0, s_tready[0]}, 32'd1);
    ramp(64, 100); run(0, 1'b0, 0, 63, -1);

    ramp(16, 0);   run(1, 1'b0, 0, 15, -1);
    rnd(16);       run(1, 1'b1, 2, 15, -1);
    ramp(16, 0);   run(2, 1'b0, 1, 15, -1);
    rnd(16);       run(2, 1'b0, 2, 15, -1);
    chk("err_n16_cp4", {31'b0, err[1]}, 32'd0);
    chk("err_n16_cp1", {31'b0, err[2]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
